// File: rtl/fetch_pkg.sv
// Shared constants and the {instruction, pc} packet type for the fetch stage.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned IMEM_AW_DEFAULT  = 14;
    localparam int unsigned INST_W           = 32;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [31:0]       pc;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid register holding a fetched {inst, pc} while decode stalls.
// Flush beats capture, and capture beats drain.
module fetch_skid
    import fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       capture,
    input  logic       drain,
    input  logic       flush,
    input  fetch_pkt_t cap_pkt,
    output logic       skid_vld,
    output fetch_pkt_t skid_pkt
);

    logic       skid_valid_q, skid_valid_d;
    fetch_pkt_t skid_pkt_q, skid_pkt_d;

    always_comb begin
        skid_valid_d = skid_valid_q;
        skid_pkt_d   = skid_pkt_q;
        if (flush) begin
            skid_valid_d = 1'b0;
        end else if (capture) begin
            skid_valid_d = 1'b1;
            skid_pkt_d   = cap_pkt;
        end else if (drain) begin
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            skid_pkt_q   <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_pkt_q   <= skid_pkt_d;
        end
    end

    assign skid_vld = skid_valid_q;
    assign skid_pkt = skid_pkt_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, drives the imem read address, and hands {inst, pc} to decode.
// The memory address is a pure register, so a stall lands in the skid instead of the address.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned IMEM_AW  = IMEM_AW_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    output logic [IMEM_AW-1:0] imem_addrb,
    input  logic [INST_W-1:0]  imem_doutb,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INST_W-1:0]  out_inst,
    output logic [31:0]        out_pc
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        req_valid_q, req_valid_d;

    logic        skid_vld;
    fetch_pkt_t  skid_pkt;
    fetch_pkt_t  req_pkt;
    logic        issue;
    logic        capture;
    logic        drain;

    assign req_pkt = '{inst: imem_doutb, pc: req_pc_q};

    // Fetch ahead only when the result has somewhere to go next cycle.
    assign issue   = ~redirect_valid & (out_ready | (~skid_vld & ~req_valid_q));
    assign capture = req_valid_q & ~out_ready & ~redirect_valid;
    assign drain   = skid_vld & out_ready;

    always_comb begin
        out_valid = (skid_vld | req_valid_q) & ~redirect_valid;
        out_inst  = '0;
        out_pc    = '0;
        if (out_valid) begin
            if (skid_vld) begin
                out_inst = skid_pkt.inst;
                out_pc   = skid_pkt.pc;
            end else begin
                out_inst = req_pkt.inst;
                out_pc   = req_pkt.pc;
            end
        end
    end

    always_comb begin
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        req_valid_d = 1'b0;
        if (redirect_valid) begin
            pc_d = redirect_pc & ~32'h3;
        end else if (issue) begin
            req_valid_d = 1'b1;
            req_pc_d    = pc_q;
            pc_d        = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            req_valid_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            req_valid_q <= req_valid_d;
        end
    end

    assign imem_addrb = pc_q[IMEM_AW+1:2];

    fetch_skid u_skid (
        .clk      (clk),
        .rst      (rst),
        .capture  (capture),
        .drain    (drain),
        .flush    (redirect_valid),
        .cap_pkt  (req_pkt),
        .skid_vld (skid_vld),
        .skid_pkt (skid_pkt)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios, then random ready/redirect against a PC-order model.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [13:0] imem_addrb;
    logic [31:0] imem_doutb;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    logic [31:0] mem [0:16383];

    int n_checks;
    int n_fail;

    fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(14)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addrb     (imem_addrb),
        .imem_doutb     (imem_doutb),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: 1-cycle registered read, cleared on reset.
    always @(posedge clk) begin
        if (rst) imem_doutb <= 32'h0;
        else     imem_doutb <= mem[imem_addrb];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input logic vld, input logic [31:0] inst,
                              input logic [31:0] pc);
        chk({tag, "_vld"}, {31'b0, out_valid}, {31'b0, vld});
        chk({tag, "_inst"}, out_inst, inst);
        chk({tag, "_pc"}, out_pc, pc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    logic [31:0] exp_pc;
    logic [31:0] r;
    logic        redir_prev;
    int          fires;

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        fires          = 0;
        rst            = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        mem[0] = 32'hA0;
        mem[1] = 32'hA1;
        mem[2] = 32'hA2;
        mem[3] = 32'hA3;

        repeat (3) tick();
        settle();
        expect_out("in_rst", 1'b0, 32'h0, 32'h0);

        // Cycle 0 after release: address at RESET_PC, nothing valid yet.
        rst = 1'b0;
        settle();
        chk("c0_vld", {31'b0, out_valid}, 32'h0);
        chk("c0_addr", {18'b0, imem_addrb}, 32'h0);

        tick(); settle();
        expect_out("c1", 1'b1, 32'hA0, 32'h0);

        // Stall for three cycles on (A1, 4).
        tick(); out_ready = 1'b0; settle();
        expect_out("c2", 1'b1, 32'hA1, 32'h4);
        chk("c2_addr", {18'b0, imem_addrb}, 32'h2);
        for (int k = 0; k < 2; k++) begin
            tick(); settle();
            expect_out("stall", 1'b1, 32'hA1, 32'h4);
            chk("stall_addr", {18'b0, imem_addrb}, 32'h2);
        end
        tick(); out_ready = 1'b1; settle();
        expect_out("release", 1'b1, 32'hA1, 32'h4);
        tick(); settle();
        expect_out("release_next", 1'b1, 32'hA2, 32'h8);

        // Redirect while streaming; A3 must never appear.
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; settle();
        expect_out("redir", 1'b0, 32'h0, 32'h0);
        tick(); redirect_valid = 1'b0; settle();
        chk("redir_t1_vld", {31'b0, out_valid}, 32'h0);
        chk("redir_t1_addr", {18'b0, imem_addrb}, 32'h40);
        tick(); settle();
        expect_out("redir_tgt", 1'b1, mem[16'h40], 32'h100);

        // Fill the skid, then redirect while stalled.
        tick(); out_ready = 1'b0; settle();
        expect_out("tgt_next", 1'b1, mem[16'h41], 32'h104);
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; settle();
        chk("skid_full_a", {31'b0, dut.u_skid.skid_valid_q}, 32'h1);
        expect_out("redir_stall", 1'b0, 32'h0, 32'h0);
        tick(); redirect_valid = 1'b0; out_ready = 1'b1; settle();
        chk("redir_stall_t1_vld", {31'b0, out_valid}, 32'h0);
        chk("redir_stall_addr", {18'b0, imem_addrb}, 32'h80);
        tick(); settle();
        expect_out("redir_stall_tgt", 1'b1, mem[16'h80], 32'h200);

        // Reset mid-stream with the skid full.
        tick(); out_ready = 1'b0; settle();
        expect_out("pre_rst", 1'b1, mem[16'h81], 32'h204);
        tick(); rst = 1'b1; settle();
        chk("skid_full_b", {31'b0, dut.u_skid.skid_valid_q}, 32'h1);
        tick(); rst = 1'b0; out_ready = 1'b1; settle();
        expect_out("mid_rst", 1'b0, 32'h0, 32'h0);
        chk("mid_rst_addr", {18'b0, imem_addrb}, 32'h0);
        tick(); settle();
        expect_out("restart0", 1'b1, 32'hA0, 32'h0);
        tick(); settle();
        expect_out("restart1", 1'b1, 32'hA1, 32'h4);

        // Random phase: accepted PCs follow pc+4 order, restarted at every redirect target.
        exp_pc     = 32'h8;
        redir_prev = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            tick();
            out_ready      = ($urandom_range(0, 99) < 70);
            redirect_valid = ($urandom_range(0, 99) < 4);
            r = $urandom;
            if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FF00 | (r & 32'hFF);
            else                           redirect_pc = r & 32'h0000_FFFF;
            settle();
            chk("invariant", {31'b0, dut.req_valid_q & dut.u_skid.skid_valid_q}, 32'h0);
            // Valid exactly when neither this nor the previous cycle redirected.
            chk("vld_rule", {31'b0, out_valid}, {31'b0, ~redirect_valid & ~redir_prev});
            if (out_valid && out_ready) begin
                chk("rand_pc", out_pc, exp_pc);
                chk("rand_inst", out_inst, mem[exp_pc[15:2]]);
                exp_pc = exp_pc + 32'd4;
                fires++;
            end
            if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
            redir_prev = redirect_valid;
        end
        chk("fire_count", {31'b0, fires >= 4000}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly downstream of the instruction memory read port (14-bit word address, 32-bit data, 1-cycle registered read, data cleared to 0 on rst). It holds the PC and drives the memory read address. It presents {instruction, PC} to decode over a valid/ready handshake. A one-entry skid buffer keeps the memory address free of any combinational dependence on out_ready; branch/jump redirects squash in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
IMEM_AW, 14, memory word-address width; addrb = pc[IMEM_AW+1:2]

Ports:
clk  in  1  clock
rst  in  1  reset (synchronous, active-high)
imem_addrb  out  IMEM_AW  memory read word address
imem_doutb  in  32  memory read data, valid 1 cycle after address
redirect_valid  in  1  redirect request from execute
redirect_pc  in  32  redirect target; bits [1:0] ignored
out_valid  out  1  instruction available to decode
out_ready  in  1  decode accepts
out_inst  out  32  instruction word
out_pc  out  32  PC of out_inst

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- State registers: pc, req_valid/req_pc (read issued last cycle, data on imem_doutb now), skid_valid/skid_inst/skid_pc.
- Reset values: pc=RESET_PC; req_valid=0; skid_valid=0; skid_inst=0; skid_pc=0. Outputs during and one cycle after reset: out_valid=0, out_inst=0, out_pc=0, imem_addrb=RESET_PC[IMEM_AW+1:2] (after reset).
- imem_addrb = pc[IMEM_AW+1:2] always. It is a pure register output with no path from out_ready or redirect_valid.
- Output mux: if skid_valid, present skid; else if req_valid, present {imem_doutb, req_pc}. out_valid = (skid_valid | req_valid) & ~redirect_valid. When out_valid=0, out_inst=0 and out_pc=0.
- fire = out_valid & out_ready.
- Invariant: skid_valid and req_valid are never both 1. The bench asserts this.
- issue = ~redirect_valid & (out_ready | (~skid_valid & ~req_valid)). On issue: req_valid<=1, req_pc<=pc, pc<=pc+4 (32-bit wrap). Without issue: req_valid<=0.
- Skid capture: if req_valid & ~out_ready & ~redirect_valid, then skid<= {imem_doutb, req_pc} and skid_valid<=1.
- Skid drain: if skid_valid & out_ready, then skid_valid<=0.
- Throughput: 1 instruction/cycle with out_ready held high. First out_valid is 1 cycle after reset release. There is no bubble on stall release.
- Redirect (highest priority below rst): in cycle t, out_valid is forced 0, pc<={redirect_pc[31:2],2'b00}, req_valid<=0, skid_valid<=0, no issue. In t+1, addrb presents the target; out_valid for the target rises in t+2.
- Redirect during stall: the skid and in-flight contents are discarded; no stale instruction is ever presented.
- rst mid-operation: all state returns to reset values at the next edge, overriding redirect and handshake.
- Address wrap: pc beyond 4*2^IMEM_AW aliases in imem_addrb. The full 32-bit pc is still reported on out_pc.

Decomposition:
- fetch_pkg: RESET_PC default, IMEM_AW default, PC_STEP=4, INST_W=32.
- Sub-module fetch_skid: one-entry skid register (capture/drain/flush, data+pc). The PC/issue logic stays in fetch_unit.

Test Plan:
- Reset release, out_ready=1, memory words 0..3 = 0xA0,0xA1,0xA2,0xA3 -> out_valid from cycle 1; (inst,pc) = (0xA0,0x0),(0xA1,0x4),(0xA2,0x8),(0xA3,0xC) on consecutive cycles.
- out_ready low for 3 cycles while (0xA1,0x4) is presented -> it is held stable, pc does not advance past 0x8, addrb is stable. After ready rises: 0xA1 then 0xA2 on back-to-back cycles, with no duplicate and no gap.
- redirect_valid=1, redirect_pc=0x0000_0103 while streaming -> out_valid=0 that cycle; next valid is (mem[0x40],0x100) two cycles later. No instruction from the old path appears after the redirect.
- Redirect asserted while the skid is full and out_ready=0 -> skid flushed; the first accepted instruction is the redirect target.
- rst asserted mid-stream with skid full -> next cycle out_valid=0, out_inst=0, out_pc=0, addrb=RESET_PC>>2. The stream restarts from RESET_PC.
- Random out_ready/redirect for 10k cycles against a reference PC model -> accepted sequence matches the model, and the invariant skid_valid&req_valid=0 never fires.
